ex4_ctrl_seq: RTL and testbench

- Upstream control stage for the 32-bit enable/clear counter with 33-bit compare vector (inputs X, Clear, C_0..C_32; outputs W, Z).
- Serially loads the 33-bit C vector, then sequences the counter through clear, run and halt by driving X and Clear.
- Consumes the counter's W (top-nibble all-ones) to stop a run.
- All outputs are registered.

---
 rtl/ex4_ctrl_seq.sv | 193 +++++++++++++++++++
 tb/tb_ex4_ctrl_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex4_ctrl_seq.sv
// ex4_ctrl_seq: upstream control stage for the enable/clear counter.
// It shifts in the counter's compare vector one bit per cycle, commits it,
// and then sequences the counter through clear, run and halt by driving
// X (x_out) and Clear (clear_out). The counter's W input ends a run.
// All outputs are registered and track the state register.
// Optional feature: define CTRL_TIMEOUT_EN to add a RUN-cycle limit
// (TIMEOUT cycles) that halts the run and sets a sticky timeout flag.
module ex4_ctrl_seq #(
    parameter int CW        = 33,
    parameter bit WRAP_STOP = 1'b1,
    parameter int TIMEOUT   = 1000
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          sin,
    input  logic          sload,
    input  logic          start,
    input  logic          stop,
    input  logic          clr_req,
    input  logic          w_in,
    output logic          x_out,
    output logic          clear_out,
    output logic [CW-1:0] c_out,
    output logic          busy,
    output logic          done,
    output logic          load_err,
    output logic          timeout
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CLEAR = 3'd2,
        ST_RUN   = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    // Bit counter saturates at CW+1 so an over-long load stays flagged.
    localparam int CNTW = $clog2(CW + 2);
    localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(CW + 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(CW);

    state_t          state_r;
    state_t          state_s;
    logic            go_run_r;   // CLEAR exits to RUN when set, else to IDLE
    logic            go_run_s;
    logic            shift_s;
    logic            commit_s;
    logic [CW-1:0]   shadow_r;
    logic [CNTW-1:0] count_r;

`ifdef CTRL_TIMEOUT_EN
    localparam int RCW = $clog2(TIMEOUT + 1);
    localparam logic [RCW-1:0] RUN_LAST = RCW'(TIMEOUT - 1);
    logic [RCW-1:0] run_cnt_r;
    logic           tmo_hit_s;
`endif

    // Next-state and datapath-strobe decode; event priorities are encoded by if-chain order.
    always_comb begin
        state_s  = state_r;
        go_run_s = go_run_r;
        shift_s  = 1'b0;
        commit_s = 1'b0;
`ifdef CTRL_TIMEOUT_EN
        tmo_hit_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (sload) begin
                    state_s = ST_LOAD;
                    shift_s = 1'b1;
                end else if (clr_req) begin
                    state_s  = ST_CLEAR;
                    go_run_s = 1'b0;
                end else if (start) begin
                    state_s  = ST_CLEAR;
                    go_run_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (sload) begin
                    shift_s = 1'b1;
                end else begin
                    commit_s = 1'b1;
                    state_s  = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (go_run_r) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (clr_req) begin
                    state_s  = ST_CLEAR;
                    go_run_s = 1'b1;
                end else if (stop) begin
                    state_s = ST_IDLE;
                end else if (WRAP_STOP && w_in) begin
                    state_s = ST_HALT;
`ifdef CTRL_TIMEOUT_EN
                end else if (run_cnt_r == RUN_LAST) begin
                    state_s   = ST_HALT;
                    tmo_hit_s = 1'b1;
`endif
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_HALT: begin
                if (clr_req) begin
                    state_s  = ST_CLEAR;
                    go_run_s = 1'b0;
                end else if (start) begin
                    state_s  = ST_CLEAR;
                    go_run_s = 1'b1;
                end else if (stop) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HALT;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                go_run_s = 1'b0;
            end
        endcase
    end

    // State register, serial-load datapath and outputs registered from the next state.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            go_run_r  <= 1'b0;
            shadow_r  <= '0;
            count_r   <= '0;
            c_out     <= '0;
            load_err  <= 1'b0;
            x_out     <= 1'b0;
            clear_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_r  <= state_s;
            go_run_r <= go_run_s;
            if (shift_s) begin
                shadow_r <= {shadow_r[CW-2:0], sin};
                if (count_r != CNT_MAX) begin
                    count_r <= count_r + CNTW'(1);
                end
            end else if (commit_s) begin
                c_out    <= shadow_r;
                load_err <= (count_r != CNT_FULL);
                count_r  <= '0;
            end
            x_out     <= (state_s == ST_RUN);
            clear_out <= (state_s == ST_CLEAR);
            busy      <= (state_s == ST_LOAD) || (state_s == ST_CLEAR) || (state_s == ST_RUN);
            done      <= (state_s == ST_HALT);
        end
    end

`ifdef CTRL_TIMEOUT_EN
    // RUN-cycle counter and sticky timeout flag, both cleared on entry to CLEAR.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            run_cnt_r <= '0;
            timeout   <= 1'b0;
        end else if (state_s == ST_CLEAR) begin
            run_cnt_r <= '0;
            timeout   <= 1'b0;
        end else begin
            if (state_r == ST_RUN) begin
                run_cnt_r <= run_cnt_r + RCW'(1);
            end
            if (tmo_hit_s) begin
                timeout <= 1'b1;
            end
        end
    end
`else
    // Without the limit the timeout flag is a constant-zero register.
    always_ff @(posedge clock) begin
        timeout <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_ex4_ctrl_seq.sv
// Self-checking bench for ex4_ctrl_seq: a per-cycle vector table for the
// run/halt/clear sequencing plus hand-written multi-cycle sequences for
// serial loads, output latency, reset mid-activity and (with
// CTRL_TIMEOUT_EN defined) the RUN-cycle limit.
module tb_ex4_ctrl_seq;

    localparam int CW = 33;
    localparam int TO = 8;

    logic          clock = 1'b0;
    logic          reset_n, sin, sload, start, stop, clr_req, w_in;
    logic          x_out, clear_out, busy, done, load_err, timeout;
    logic [CW-1:0] c_out;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model of the architectural load state.
    logic [CW-1:0] shadow_m = '0;
    logic [CW-1:0] c_m      = '0;
    logic          err_m    = 1'b0;

    typedef struct {
        string      name;
        logic [6:0] in;   // {reset_n, sload, sin, start, stop, clr_req, w_in}
        logic [3:0] ex;   // {x_out, clear_out, busy, done}
    } vec_t;
    vec_t tbl[$];

    ex4_ctrl_seq #(.CW(CW), .WRAP_STOP(1'b1), .TIMEOUT(TO)) dut (
        .clock(clock), .reset_n(reset_n), .sin(sin), .sload(sload),
        .start(start), .stop(stop), .clr_req(clr_req), .w_in(w_in),
        .x_out(x_out), .clear_out(clear_out), .c_out(c_out), .busy(busy),
        .done(done), .load_err(load_err), .timeout(timeout)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic [6:0] in, input logic [3:0] ex);
        vec_t v;
        v.name = nm;
        v.in   = in;
        v.ex   = ex;
        tbl.push_back(v);
    endtask

    task automatic idle_inputs();
        sload = 1'b0; sin = 1'b0; start = 1'b0; stop = 1'b0; clr_req = 1'b0; w_in = 1'b0;
    endtask

    // Shift nbits of val (MSB first); noise drives start/stop/clr_req, which LOAD ignores.
    task automatic do_load(input string nm, input logic [63:0] val, input int nbits, input logic noise);
        for (int i = nbits - 1; i >= 0; i--) begin
            sload = 1'b1; sin = val[i]; start = noise; stop = noise; clr_req = noise;
            tick();
            shadow_m = {shadow_m[CW-2:0], val[i]};
            chk({nm, "_busy"}, 64'(busy), 64'(1'b1));
            chk({nm, "_c_hold"}, 64'(c_out), 64'(c_m));
        end
        idle_inputs();
        tick();
        c_m   = shadow_m;
        err_m = (nbits != CW);
        chk({nm, "_c_out"}, 64'(c_out), 64'(c_m));
        chk({nm, "_load_err"}, 64'(load_err), 64'(err_m));
        chk({nm, "_busy_end"}, 64'(busy), 64'(1'b0));
        chk({nm, "_no_clear"}, 64'(clear_out), 64'(1'b0));
    endtask

    localparam logic [3:0] E_IDLE = 4'b0000;
    localparam logic [3:0] E_CLR  = 4'b0110;
    localparam logic [3:0] E_RUN  = 4'b1010;
    localparam logic [3:0] E_HALT = 4'b0001;

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        tick();
        chk("rst_x", 64'(x_out), 64'(1'b0));
        chk("rst_clear", 64'(clear_out), 64'(1'b0));
        chk("rst_c", 64'(c_out), 64'(0));
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_done", 64'(done), 64'(1'b0));
        chk("rst_err", 64'(load_err), 64'(1'b0));
        chk("rst_tmo", 64'(timeout), 64'(1'b0));
        reset_n = 1'b1;
        tick();

        // ---------------- serial loads ----------------
        do_load("ld33", 64'h1_0000_0005, 33, 1'b0);
        do_load("ld32", 64'hDEAD_BEEF, 32, 1'b1);
        chk("ld32_value", 64'(c_out), 64'h1_DEAD_BEEF);
        do_load("ld33b", 64'h0_A5A5_5A5A, 33, 1'b0);
        do_load("ld40", 64'hF0_1234_5678, 40, 1'b0);

        // ---------------- vector table ----------------
        //        name          {rst,sload,sin,start,stop,clr,w}  {x,clr,busy,done}
        add("t_reset",      7'b0000000, E_IDLE);
        add("t_idle",       7'b1000000, E_IDLE);
        add("t_start",      7'b1001000, E_CLR);
        add("t_clr_in_clr", 7'b1000010, E_RUN);
        add("t_start_run",  7'b1001000, E_RUN);
        add("t_w_halt",     7'b1000001, E_HALT);
        add("t_halt_hold",  7'b1000000, E_HALT);
        add("t_halt_st_sp", 7'b1001100, E_CLR);
        add("t_rerun",      7'b1000000, E_RUN);
        add("t_run_sp_clr", 7'b1000110, E_CLR);
        add("t_restart",    7'b1000000, E_RUN);
        add("t_run_stop",   7'b1000100, E_IDLE);
        add("t_idle_clr_st",7'b1001010, E_CLR);
        add("t_clr_to_idle",7'b1000000, E_IDLE);
        add("t_start2",     7'b1001000, E_CLR);
        add("t_run2",       7'b1000000, E_RUN);
        add("t_halt2",      7'b1000001, E_HALT);
        add("t_halt_clr_st",7'b1001010, E_CLR);
        add("t_clr_idle2",  7'b1000000, E_IDLE);
        add("t_start3",     7'b1001000, E_CLR);
        add("t_run3",       7'b1000000, E_RUN);
        add("t_rst_run",    7'b0000000, E_IDLE);
        add("t_idle3",      7'b1000000, E_IDLE);
        add("t_start4",     7'b1001000, E_CLR);
        add("t_run4",       7'b1000000, E_RUN);
        add("t_stop_over_w",7'b1000101, E_IDLE);
        add("t_start5",     7'b1001000, E_CLR);
        add("t_run5",       7'b1000000, E_RUN);
        add("t_halt5",      7'b1000001, E_HALT);
        add("t_sload_halt", 7'b1100000, E_HALT);
        add("t_halt_stop",  7'b1000100, E_IDLE);
        add("t_sload_run_a",7'b1001000, E_CLR);
        add("t_sload_run_b",7'b1100000, E_RUN);
        add("t_sload_run_c",7'b1100100, E_IDLE);

        foreach (tbl[k]) begin
            {reset_n, sload, sin, start, stop, clr_req, w_in} = tbl[k].in;
            tick();
            if (!tbl[k].in[6]) begin
                shadow_m = '0; c_m = '0; err_m = 1'b0;
            end
            chk({tbl[k].name, "_x"},     64'(x_out),     64'(tbl[k].ex[3]));
            chk({tbl[k].name, "_clear"}, 64'(clear_out), 64'(tbl[k].ex[2]));
            chk({tbl[k].name, "_busy"},  64'(busy),      64'(tbl[k].ex[1]));
            chk({tbl[k].name, "_done"},  64'(done),      64'(tbl[k].ex[0]));
            chk({tbl[k].name, "_c"},     64'(c_out),     64'(c_m));
            chk({tbl[k].name, "_err"},   64'(load_err),  64'(err_m));
            chk({tbl[k].name, "_tmo"},   64'(timeout),   64'(1'b0));
        end
        reset_n = 1'b1;
        idle_inputs();
        tick();

`ifndef CTRL_TIMEOUT_EN
        // ---------------- start latency and W stop ----------------
        start = 1'b1;
        tick();                 // cycle t+1
        start = 1'b0;
        chk("lat_t1_clear", 64'(clear_out), 64'(1'b1));
        chk("lat_t1_x", 64'(x_out), 64'(1'b0));
        tick();                 // cycle t+2
        chk("lat_t2_x", 64'(x_out), 64'(1'b1));
        chk("lat_t2_busy", 64'(busy), 64'(1'b1));
        for (int i = 3; i <= 10; i++) begin
            tick();
            chk($sformatf("lat_t%0d_x", i), 64'(x_out), 64'(1'b1));
        end
        w_in = 1'b1;
        tick();                 // cycle t+11
        w_in = 1'b0;
        chk("lat_t11_x", 64'(x_out), 64'(1'b0));
        chk("lat_t11_done", 64'(done), 64'(1'b1));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("lat_back_idle", 64'(done), 64'(1'b0));
`endif

        // ---------------- reset during a load ----------------
        do_load("ld_pre", 64'h1234_5678, 32, 1'b0);
        for (int i = 0; i < 10; i++) begin
            sload = 1'b1; sin = i[0];
            tick();
        end
        chk("mid_ld_busy", 64'(busy), 64'(1'b1));
        chk("mid_ld_c_hold", 64'(c_out), 64'(c_m));
        sload = 1'b0; reset_n = 1'b0;
        tick();
        shadow_m = '0; c_m = '0; err_m = 1'b0;
        chk("rst_ld_c", 64'(c_out), 64'(0));
        chk("rst_ld_busy", 64'(busy), 64'(1'b0));
        chk("rst_ld_err", 64'(load_err), 64'(1'b0));
        reset_n = 1'b1;
        tick();
        chk("rst_ld_stay_idle", 64'(busy), 64'(1'b0));
        chk("rst_ld_c_stays", 64'(c_out), 64'(0));

`ifdef CTRL_TIMEOUT_EN
        // ---------------- RUN-cycle limit ----------------
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("to_clear", 64'(clear_out), 64'(1'b1));
        for (int i = 0; i < TO; i++) begin
            tick();
            chk($sformatf("to_run%0d_x", i), 64'(x_out), 64'(1'b1));
            chk($sformatf("to_run%0d_tmo", i), 64'(timeout), 64'(1'b0));
        end
        tick();
        chk("to_x_drop", 64'(x_out), 64'(1'b0));
        chk("to_done", 64'(done), 64'(1'b1));
        chk("to_flag", 64'(timeout), 64'(1'b1));
        tick();
        chk("to_flag_sticky", 64'(timeout), 64'(1'b1));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("to_restart_clear", 64'(clear_out), 64'(1'b1));
        chk("to_restart_flag", 64'(timeout), 64'(1'b0));
        tick();
        chk("to_restart_x", 64'(x_out), 64'(1'b1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
